// File: rtl/mult_rr_sched.sv
// rtl/mult_rr_sched.sv - round-robin scheduler sharing one init/done shift-add multiplier
// Optional watchdog on the multiplier wait: MULT_TIMEOUT_EN.
module mult_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int TMO  = 64,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    output logic              rsp_err,
    output logic              busy,
    output logic              m_init,
    output logic [W-1:0]      m_a,
    output logic [W-1:0]      m_b,
    input  logic              m_done,
    input  logic [2*W-1:0]    m_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_REL
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [NREQ-1:0]   r_gnt;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [2*W-1:0]    r_rsp_prod;
    logic              r_m_init;
    logic [W-1:0]      r_m_a;
    logic [W-1:0]      r_m_b;
    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_j;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              w_start;
    logic              w_tmo;

    // First requester at or above the pointer, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = ID_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_j]) begin
                w_found = 1'b1;
                w_idx   = w_j;
            end
        end
    end

    assign w_ptr_nxt = ID_W'((int'(w_idx) + 1) % NREQ);
    // A done level left over from a previous job blocks new grants.
    assign w_start   = w_found && !m_done;

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic          r_tmo_hit;
    logic          r_rsp_err;

    assign w_tmo = !m_done && (r_tmo_cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_tmo_hit <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= 1'b0;
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
                r_tmo_hit <= 1'b0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
                if (w_tmo) r_tmo_hit <= 1'b1;
            end else if (r_state == S_CAPT) begin
                r_rsp_err <= r_tmo_hit;
            end
        end
    end
    assign rsp_err = r_rsp_err;
`else
    assign w_tmo   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (m_done || w_tmo) w_next = S_CAPT;
            S_CAPT:  w_next = S_REL;
            S_REL:   if (!m_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
            r_m_init    <= 1'b0;
            r_m_a       <= '0;
            r_m_b       <= '0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_gnt <= NREQ'(1) << w_idx;
                        r_m_a <= a_in[w_idx*W +: W];
                        r_m_b <= b_in[w_idx*W +: W];
                        r_id  <= w_idx;
                        r_ptr <= w_ptr_nxt;
                    end
                end
                S_ISSUE: r_m_init <= 1'b1;
                S_CAPT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_m_init    <= 1'b0;
`ifdef MULT_TIMEOUT_EN
                    r_rsp_prod  <= r_tmo_hit ? '0 : m_result;
`else
                    r_rsp_prod  <= m_result;
`endif
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_prod  = r_rsp_prod;
    assign busy      = (r_state != S_IDLE);
    assign m_init    = r_m_init;
    assign m_a       = r_m_a;
    assign m_b       = r_m_b;

endmodule
